// File: rtl/knights_pkg.sv
// Shared constants for the Knight's Tour remote link: response codes, opcodes,
// headings, UART timing default and the command sequencer state type.
package knights_pkg;

    localparam int DEFAULT_BAUD_DIV = 434;

    localparam logic [7:0] RESP_DONE = 8'hA5;

    typedef enum logic [3:0] {
        CAL          = 4'h2,
        MOVE         = 4'h4,
        MOVE_FANFARE = 4'h5,
        TOUR         = 4'h6
    } opcode_t;

    localparam logic [7:0] NORTH = 8'h00;
    localparam logic [7:0] WEST  = 8'h3F;
    localparam logic [7:0] SOUTH = 8'h7F;
    localparam logic [7:0] EAST  = 8'hBF;

    typedef enum logic [2:0] {
        IDLE,
        SEND_HI,
        WAIT_HI,
        SEND_LO,
        WAIT_LO
    } cmd_state_t;

endpackage

// File: rtl/remote_comm_uart.sv
// Full-duplex 8N1 UART: independent transmit and receive engines sharing only
// the clock and reset.
module uart #(
    parameter int BAUD_DIV = 434,
    parameter int HALF_DIV = BAUD_DIV / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       tx,
    input  logic       rx,
    input  logic       clr_rx_rdy,
    output logic       rx_rdy,
    output logic [7:0] rx_data
);

    localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
    localparam logic [11:0] HALF_LAST = 12'(HALF_DIV - 1);

    logic        tx_busy;
    logic [11:0] tx_baud;
    logic [3:0]  tx_bits;
    logic [8:0]  tx_shift;

    // tx_bits: 0 = start, 1..8 = data, 9 = stop; tx is registered so the
    // start bit shows the cycle after the load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_busy  <= 1'b0;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
            tx_baud  <= '0;
            tx_bits  <= '0;
            tx_shift <= '1;
        end else begin
            tx_done <= 1'b0;
            if (trmt && !tx_busy) begin
                tx_busy  <= 1'b1;
                tx       <= 1'b0;
                tx_shift <= {1'b1, tx_data};
                tx_baud  <= '0;
                tx_bits  <= '0;
            end else if (tx_busy) begin
                if (tx_baud == BAUD_LAST) begin
                    tx_baud <= '0;
                    if (tx_bits == 4'd9) begin
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                        tx      <= 1'b1;
                    end else begin
                        tx_bits  <= tx_bits + 4'd1;
                        tx       <= tx_shift[0];
                        tx_shift <= {1'b1, tx_shift[8:1]};
                    end
                end else begin
                    tx_baud <= tx_baud + 12'd1;
                end
            end
        end
    end

    logic        rx_meta;
    logic        rx_sync;
    logic        rx_prev;
    logic        rx_busy;
    logic [11:0] rx_baud;
    logic [3:0]  rx_bits;
    logic [7:0]  rx_shift;
    logic        rx_sample;

    assign rx_sample = (rx_bits == 4'd0) ? (rx_baud == HALF_LAST) : (rx_baud == BAUD_LAST);

    // Setting rx_rdy is written after the clear so a completing byte wins
    // over a same-cycle clear request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_busy  <= 1'b0;
            rx_baud  <= '0;
            rx_bits  <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_rdy   <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            if (clr_rx_rdy) begin
                rx_rdy <= 1'b0;
            end
            if (!rx_busy) begin
                if (rx_prev && !rx_sync) begin
                    rx_busy <= 1'b1;
                    rx_baud <= '0;
                    rx_bits <= '0;
                    rx_rdy  <= 1'b0;
                end
            end else if (rx_sample) begin
                rx_baud <= '0;
                rx_bits <= rx_bits + 4'd1;
                if (rx_bits == 4'd9) begin
                    rx_busy <= 1'b0;
                    rx_data <= rx_shift;
                    rx_rdy  <= 1'b1;
                end else if (rx_bits != 4'd0) begin
                    rx_shift <= {rx_sync, rx_shift[7:1]};
                end
            end else begin
                rx_baud <= rx_baud + 12'd1;
            end
        end
    end

endmodule

// File: rtl/remote_comm.sv
// Remote command sender: sends a 16-bit command as two UART bytes (high first)
// and reports single-byte responses from the robot.
module remote_comm
    import knights_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV,
    parameter int HALF_DIV = BAUD_DIV / 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] cmd,
    input  logic        send_cmd,
    output logic        cmd_sent,
    output logic        resp_rdy,
    output logic [7:0]  resp
);

    cmd_state_t  state;
    cmd_state_t  next_state;
    logic [15:0] cmd_hold;
    logic        accept;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        trmt       = 1'b0;
        tx_data    = cmd_hold[15:8];
        case (state)
            IDLE: begin
                if (send_cmd) begin
                    accept     = 1'b1;
                    next_state = SEND_HI;
                end
            end
            SEND_HI: begin
                trmt       = 1'b1;
                next_state = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_done) begin
                    next_state = SEND_LO;
                end
            end
            SEND_LO: begin
                trmt       = 1'b1;
                tx_data    = cmd_hold[7:0];
                next_state = WAIT_LO;
            end
            WAIT_LO: begin
                if (tx_done) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The holding register frees cmd to change right after the strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_hold <= '0;
            cmd_sent <= 1'b0;
        end else if (accept) begin
            cmd_hold <= cmd;
            cmd_sent <= 1'b0;
        end else if (state == WAIT_LO && tx_done) begin
            cmd_sent <= 1'b1;
        end
    end

    uart #(
        .BAUD_DIV (BAUD_DIV),
        .HALF_DIV (HALF_DIV)
    ) u_uart (
        .clk        (clk),
        .rst_n      (rst_n),
        .trmt       (trmt),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .tx         (TX),
        .rx         (RX),
        .clr_rx_rdy (accept),
        .rx_rdy     (resp_rdy),
        .rx_data    (resp)
    );

endmodule

// File: tb/tb_remote_comm.sv
// Bench for remote_comm: decodes TX frames with a bench-side UART, drives RX
// frames, and compares against expectations derived from the command rules.
module tb_remote_comm;

    localparam int BD   = 434;
    localparam int HALF = BD / 2;
    localparam int WAIT_LIM = 12 * BD;

    logic        clk;
    logic        rst_n;
    logic        rx_line;
    logic        tx_line;
    logic [15:0] cmd;
    logic        send_cmd;
    logic        cmd_sent;
    logic        resp_rdy;
    logic [7:0]  resp;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    remote_comm #(.BAUD_DIV(BD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .RX       (rx_line),
        .TX       (tx_line),
        .cmd      (cmd),
        .send_cmd (send_cmd),
        .cmd_sent (cmd_sent),
        .resp_rdy (resp_rdy),
        .resp     (resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(95000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Decode one 8N1 byte from TX; gap = cycles waited before the start bit.
    task automatic capture(output logic [7:0] b, output int gap);
        logic s[10*BD];
        int bad;
        gap = 0;
        b = 8'hxx;
        while (tx_line !== 1'b0 && gap < WAIT_LIM) begin
            tick(1);
            gap++;
        end
        check("tx_start_seen", {31'd0, tx_line}, 32'd0);
        if (tx_line !== 1'b0) return;
        for (int i = 0; i < 10 * BD; i++) begin
            s[i] = tx_line;
            tick(1);
        end
        for (int k = 0; k < 8; k++) b[k] = s[(k + 1) * BD + HALF];
        check("stop_bit", {31'd0, s[9*BD + HALF]}, 32'd1);
        bad = 0;
        for (int i = 0; i < 10 * BD; i++) begin
            if ((i % BD) >= 1 && (i % BD) <= BD - 2 && s[i] !== s[(i / BD) * BD + HALF]) bad++;
        end
        check("bit_timing", bad, 0);
    endtask

    task automatic send_rx(input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_line = fr[i];
            tick(BD);
        end
    endtask

    task automatic wait_rdy(input string name, input logic val, input int limit);
        int n;
        n = 0;
        while (resp_rdy !== val && n < limit) begin
            tick(1);
            n++;
        end
        check(name, {31'd0, resp_rdy}, {31'd0, val});
    endtask

    task automatic run_cmd(input logic [15:0] c, input logic [7:0] hi, input logic [7:0] lo, input bit extra);
        logic [7:0] b0, b1;
        int g0, g1, cs, n, lows;
        cmd = c;
        send_cmd = 1'b1;
        cs = cyc;
        tick(1);
        send_cmd = 1'b0;
        cmd = 16'($urandom);
        check("cmd_sent_clr", {31'd0, cmd_sent}, 32'd0);
        fork
            begin
                capture(b0, g0);
                capture(b1, g1);
            end
            begin
                if (extra) begin
                    tick(3 * BD);
                    send_cmd = 1'b1;
                    cmd = 16'hFFFF;
                    tick(1);
                    send_cmd = 1'b0;
                end
            end
        join
        check("byte_hi", b0, hi);
        check("byte_lo", b1, lo);
        check("byte_gap_le3", {31'd0, (g1 <= 3)}, 32'd1);
        n = 0;
        while (cmd_sent !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        check("cmd_sent_set", {31'd0, cmd_sent}, 32'd1);
        check("cmd_sent_time", {31'd0, ((cyc - cs) >= 20 * BD) && ((cyc - cs) <= 20 * BD + 8)}, 32'd1);
        if (extra) begin
            lows = 0;
            for (int i = 0; i < 3 * BD; i++) begin
                if (tx_line !== 1'b1) lows++;
                tick(1);
            end
            check("no_third_byte", lows, 0);
            check("cmd_sent_hold", {31'd0, cmd_sent}, 32'd1);
        end
    endtask

    typedef struct {
        logic [15:0] c;
        logic [7:0]  hi;
        logic [7:0]  lo;
        bit          extra;
    } vec_t;

    vec_t vecs[2];

    initial begin
        int c0, lows;
        logic [15:0] rc;
        logic [7:0] rr;
        int dly;

        vecs[0] = '{c: 16'h2000, hi: 8'h20, lo: 8'h00, extra: 1'b0};
        vecs[1] = '{c: 16'h43F1, hi: 8'h43, lo: 8'hF1, extra: 1'b1};

        rst_n = 1'b0;
        rx_line = 1'b1;
        cmd = 16'h0000;
        send_cmd = 1'b0;
        tick(2);
        check("rst_tx", {31'd0, tx_line}, 32'd1);
        check("rst_cmd_sent", {31'd0, cmd_sent}, 32'd0);
        check("rst_resp_rdy", {31'd0, resp_rdy}, 32'd0);
        check("rst_resp", resp, 8'h00);
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 50; i++) begin
            if (tx_line !== 1'b1) lows++;
            tick(1);
        end
        check("rst_tx_quiet", lows, 0);

        for (int v = 0; v < 2; v++) run_cmd(vecs[v].c, vecs[v].hi, vecs[v].lo, vecs[v].extra);

        // Single 0xA5 response and its timing relative to the start edge
        c0 = cyc;
        fork
            send_rx(8'hA5);
            begin
                wait_rdy("rdy_a5", 1'b1, 11 * BD);
                check("rdy_a5_time", {31'd0, ((cyc - c0) >= 9 * BD + HALF - 2) && ((cyc - c0) <= 9 * BD + HALF + 6)}, 32'd1);
                check("resp_a5", resp, 8'hA5);
            end
        join
        run_cmd(16'h6000, 8'h60, 8'h00, 1'b0);
        check("rdy_cleared_by_cmd", {31'd0, resp_rdy}, 32'd0);
        check("resp_kept", resp, 8'hA5);

        // Back-to-back responses
        c0 = cyc;
        fork
            begin
                send_rx(8'h5A);
                send_rx(8'hA5);
            end
            begin
                wait_rdy("rdy_5a", 1'b1, 11 * BD);
                check("resp_5a", resp, 8'h5A);
                wait_rdy("rdy_drop", 1'b0, 2 * BD);
                check("rdy_drop_time", {31'd0, ((cyc - c0) >= 10 * BD) && ((cyc - c0) <= 10 * BD + 6)}, 32'd1);
                wait_rdy("rdy_2nd", 1'b1, 11 * BD);
                check("resp_2nd", resp, 8'hA5);
            end
        join

        // Reset in the middle of a transmitted byte
        cmd = 16'h2000;
        send_cmd = 1'b1;
        tick(1);
        send_cmd = 1'b0;
        lows = 0;
        while (tx_line !== 1'b0 && lows < 20) begin
            tick(1);
            lows++;
        end
        tick(5 * BD + 10);
        rst_n = 1'b0;
        tick(1);
        check("midrst_tx", {31'd0, tx_line}, 32'd1);
        check("midrst_cmd_sent", {31'd0, cmd_sent}, 32'd0);
        check("midrst_resp_rdy", {31'd0, resp_rdy}, 32'd0);
        tick(1);
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 2 * BD; i++) begin
            if (tx_line !== 1'b1) lows++;
            tick(1);
        end
        check("midrst_quiet", lows, 0);
        run_cmd(16'h4BF1, 8'h4B, 8'hF1, 1'b0);

        // Randomized full-duplex traffic against the reference model
        for (int it = 0; it < 2; it++) begin
            rc  = 16'($urandom);
            rr  = 8'($urandom);
            dly = $urandom_range(1, 5 * BD);
            fork
                run_cmd(rc, 8'(rc / 256), 8'(rc % 256), 1'b0);
                begin
                    tick(dly);
                    send_rx(rr);
                end
            join
            check("rand_resp", resp, rr);
            check("rand_rdy", {31'd0, resp_rdy}, 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/remote_comm.md
Name: remote_comm

Overview:
- Bench-side/remote command sender for the Knight's Tour robot.
- Accepts a 16-bit command and serializes it over UART TX as two 8N1 bytes, high byte first.
- Receives single-byte responses (e.g. 0xA5 = done) on RX.
- Contains its own UART transmitter/receiver; sits opposite the robot's UART wrapper.

Parameters:
- BAUD_DIV, 434, clock cycles per UART bit (50 MHz / 115200).
- HALF_DIV, BAUD_DIV/2, cycles from start-bit falling edge to mid-bit sample point.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- RX  in  1  serial input from robot; asynchronous to clk, idle high.
- TX  out  1  serial output to robot, idle high.
- cmd  in  16  command word; [15:12] opcode, [11:0] operands.
- send_cmd  in  1  one-cycle strobe: latch cmd and start transmission.
- cmd_sent  out  1  high once both bytes are fully transmitted.
- resp_rdy  out  1  high when a response byte is valid in resp.
- resp  out  8  last received response byte.

Behaviour:
- Reset (rst_n low at posedge clk) values:
  - TX=1, cmd_sent=0, resp_rdy=0, resp=8'h00.
  - All counters zero; command FSM in IDLE; receiver idle.
- Reset mid-frame aborts immediately; TX returns high the next cycle.
- Command FSM states: IDLE, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO.
  - IDLE + send_cmd: capture cmd into a 16-bit holding register; clear cmd_sent; go to SEND_HI.
  - SEND_HI: load cmd[15:8] into the transmitter; go to WAIT_HI.
  - WAIT_HI: on tx_done, go to SEND_LO.
  - SEND_LO: load cmd[7:0] into the transmitter; go to WAIT_LO.
  - WAIT_LO: on tx_done, set cmd_sent=1; go to IDLE.
- send_cmd asserted outside IDLE is ignored. cmd may change after the strobe cycle.
- cmd_sent holds 1 until the next accepted send_cmd.
- Transmitter:
  - 10-bit frame: start 0, data LSB first, stop 1.
  - Each bit is held exactly BAUD_DIV cycles; full frame = 10*BAUD_DIV cycles.
  - Start bit appears on TX the cycle after load.
  - tx_done pulses one cycle at the end of the stop bit.
  - Back-to-back bytes: the second start bit follows the first stop bit within 3 cycles.
- Receiver:
  - RX passes through a 2-flop synchronizer, preset to 1 on reset.
  - Falling edge while idle begins a frame.
  - First sample at HALF_DIV (start bit), then every BAUD_DIV: 8 data bits LSB first, then stop.
  - At the stop-bit sample: load resp with the shifted byte; set resp_rdy=1.
  - Stop-bit value is not checked; no framing-error output.
  - resp_rdy clears on an accepted send_cmd or on detection of the next start bit.
  - A new byte overwrites resp.
- Simultaneous events:
  - Same-cycle RX completion and accepted send_cmd: resp_rdy=1 wins (response not lost).
  - TX and RX operate fully independently (full duplex).
- Widths: baud counters 12-bit unsigned, bit counters 4-bit. No arithmetic on cmd.

Decomposition:
- Package knights_pkg:
  - RESP_DONE=8'hA5.
  - Opcodes: CAL=4'h2, MOVE=4'h4, MOVE_FANFARE=4'h5, TOUR=4'h6.
  - Headings: NORTH=8'h00, WEST=8'h3F, SOUTH=8'h7F, EAST=8'hBF.
  - Default BAUD_DIV.
- Sub-module uart:
  - Contains the tx and rx engines.
  - Exposes trmt, tx_data, tx_done, rx_rdy, rx_data, clr_rx_rdy.
  - remote_comm wraps it with the command FSM and holding register.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> TX=1, cmd_sent=0, resp_rdy=0, resp=00; no TX activity for 50 cycles.
- cmd=16'h2000 with send_cmd pulse:
  - Bench UART decodes bytes 0x20 then 0x00, each bit BAUD_DIV±1 cycles.
  - cmd_sent rises about 20*BAUD_DIV cycles later and stays high.
- cmd=16'h43F1 (move west 1):
  - Decoded bytes are 0x43, 0xF1.
  - A second send_cmd pulse during transmission is ignored; exactly 2 bytes are sent.
- Bench drives 0xA5 frame on RX:
  - resp=8'hA5 and resp_rdy=1 about 9.5*BAUD_DIV cycles after the start edge.
  - Next send_cmd clears resp_rdy.
- Responses 0x5A then 0xA5 back-to-back on RX -> resp_rdy drops at second start bit; final resp=0xA5, resp_rdy=1.
- Reset asserted mid-frame (after 5 bits of 0x20) -> TX=1 next cycle, cmd_sent=0; a fresh cmd=16'h4BF1 then sends 0x4B, 0xF1 correctly.
